// File: rtl/fetch_stage_pkg.sv
// Shared core constants for the fetch front end: datapath width, instruction
// width, sequential PC step and the canonical NOP encoding.
package fetch_stage_pkg;

    localparam int unsigned CORE_BITS = 32;
    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned PC_INCR   = 4;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Occupancy of the two-entry fetch buffer (0..2).
    typedef logic [1:0] fifo_cnt_t;

endpackage

// File: rtl/fetch_stage_buffer.sv
// Two-entry shift FIFO between IMEM and decode. Entry 0 is always the head,
// so the head and valid flag leave the block straight from flops.
module fetch_buffer
    import fetch_stage_pkg::*;
#(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  logic [W-1:0] i_push_data,
    output fifo_cnt_t    o_count,
    output logic         o_valid,
    output logic [W-1:0] o_head
);

    fifo_cnt_t    r_count;
    logic         r_valid;
    logic [W-1:0] r_entry0;
    logic [W-1:0] r_entry1;

    fifo_cnt_t    w_count_next;
    logic [W-1:0] w_entry0_next;
    logic [W-1:0] w_entry1_next;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_count_next  = r_count;
        w_entry0_next = r_entry0;
        w_entry1_next = r_entry1;
        if (i_flush) begin
            w_count_next = '0;
        end else if (i_push && i_pop) begin
            if (r_count == 2'd2) begin
                w_entry0_next = r_entry1;
                w_entry1_next = i_push_data;
            end else begin
                w_entry0_next = i_push_data;
            end
        end else if (i_push) begin
            if (r_count == 2'd0) w_entry0_next = i_push_data;
            else                 w_entry1_next = i_push_data;
            w_count_next = r_count + 2'd1;
        end else if (i_pop) begin
            w_entry0_next = r_entry1;
            w_count_next  = r_count - 2'd1;
        end
    end

    // NOTE: storage is reset too, because decode must read zero on out_pc/out_instr during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state is always assigned with non-blocking <=.
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_entry0 <= '0;
            r_entry1 <= '0;
        end else begin
            r_count  <= w_count_next;
            r_valid  <= (w_count_next != 2'd0);
            r_entry0 <= w_entry0_next;
            r_entry1 <= w_entry1_next;
        end
    end

    assign o_count = r_count;
    assign o_valid = r_valid;
    assign o_head  = r_entry0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_push && !i_pop && !i_flush && r_count == 2'd2));

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_pop && !i_flush && r_count == 2'd0));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: issues IMEM reads under a credit limit of two (buffered
// plus in flight), tags responses with their PC and handles redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned     bits            = CORE_BITS,
    parameter int unsigned     addr_width_IMEM = 10,
    parameter logic [bits-1:0] reset_pc        = '0
) (
    input  logic                       clk,
    input  logic                       async_reset,
    input  logic                       redirect_valid,
    input  logic [bits-1:0]            redirect_pc,
    output logic                       imem_req,
    output logic [addr_width_IMEM-1:0] imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [bits-1:0]            out_pc,
    output logic [INSTR_W-1:0]         out_instr
);

    localparam int unsigned ENTRY_W = bits + INSTR_W;

    logic [bits-1:0]    r_pc;
    logic [bits-1:0]    r_inflight_pc;
    logic               r_inflight;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic               w_room;
    logic               w_pc_en;
    logic [bits-1:0]    w_pc_next;
    logic [2:0]         w_occ;
    fifo_cnt_t          w_count;
    logic               w_valid;
    logic [ENTRY_W-1:0] w_head;

    assign w_pop  = w_valid & out_ready;
    assign w_occ  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_room = (w_occ < 3'd2);

    // Gating with the reset pin keeps the strobe low during reset yet lets the
    // first request go out in the very cycle reset is released.
    assign w_issue = async_reset & ~redirect_valid & w_room;

    // A redirect kills the response arriving this cycle; responses issued
    // before a reset never count because r_inflight is cleared by it.
    assign w_push = r_inflight & ~redirect_valid;

    assign w_pc_en   = redirect_valid | w_issue;
    assign w_pc_next = redirect_valid ? (redirect_pc & ~bits'(3))
                                      : (r_pc + bits'(PC_INCR));

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_pc <= reset_pc;
        end else if (w_pc_en) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) r_inflight_pc <= r_pc;
        end
    end

    fetch_buffer #(
        .W (ENTRY_W)
    ) u_buffer (
        .clk         (clk),
        .rst_n       (async_reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .i_push_data ({r_inflight_pc, imem_rdata}),
        .o_count     (w_count),
        .o_valid     (w_valid),
        .o_head      (w_head)
    );

    assign imem_req  = w_issue;
    assign imem_addr = r_pc[addr_width_IMEM+1:2];
    assign out_valid = w_valid;
    assign out_pc    = w_head[ENTRY_W-1:INSTR_W];
    assign out_instr = w_head[INSTR_W-1:0];

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter bits, default 32: datapath/PC width.
REQ-002 Parameter addr_width_IMEM, default 10: IMEM word-address width.
REQ-003 Parameter reset_pc, default 0: PC value loaded on reset.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 async_reset  input  1  asynchronous, active-low reset; low clears all state immediately, independent of clk.
REQ-006 redirect_valid  input  1  branch/jump redirect from execute.
REQ-007 redirect_pc  input  bits  redirect target.
REQ-008 imem_req  output  1  IMEM read strobe.
REQ-009 imem_addr  output  addr_width_IMEM  IMEM word address, = pc[addr_width_IMEM+1:2].
REQ-010 imem_rdata  input  32  instruction word, valid exactly one cycle after imem_req.
REQ-011 out_valid  output  1  decode-side entry available.
REQ-012 out_ready  input  1  decode accepts the entry.
REQ-013 out_pc  output  bits  PC of the presented instruction.
REQ-014 out_instr  output  32  presented instruction.

Function
REQ-015 The PC register SHALL advance by 4 on each issued request, wrapping modulo 2**bits.
REQ-016 A transfer SHALL occur in any cycle with out_valid=1 and out_ready=1; out_pc/out_instr SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 Fetched words SHALL be held in a 2-entry FIFO of {pc, instr}; out_* SHALL present the FIFO head, registered (no combinational path from imem_rdata).
REQ-018 imem_req SHALL assert only when (fifo_count - pop + inflight) < 2, where inflight = request issued in the previous cycle and not killed.
REQ-019 The response arriving the cycle after a non-killed request SHALL be written to the FIFO tail with the PC of that request.
REQ-020 Latency: request in cycle N -> out_valid in cycle N+2; with out_ready held 1, throughput SHALL be one instruction per cycle.
REQ-021 With redirect_valid=1 in cycle N: imem_req=0 in N; FIFO flushed at end of N; any in-flight response arriving in N or N+1 from a pre-redirect request discarded; pc <= {redirect_pc[bits-1:2], 2'b00}; first request at new PC in N+1.
REQ-022 Redirect and pop in the same cycle: the pop SHALL count as a completed transfer, then the flush applies; out_valid=0 in N+1.
REQ-023 Redirect SHALL take priority over issue, FIFO write and PC increment.
REQ-024 FIFO SHALL never overflow; no write SHALL occur when full (guaranteed by REQ-018; an assertion SHALL check it).
REQ-025 Back-to-back redirects SHALL each restart fetch; only the last target's stream reaches decode.

Reset
REQ-026 While async_reset=0: pc=reset_pc, fifo_count=0, inflight=0, out_valid=0, imem_req=0; out_pc/out_instr read 0.
REQ-027 A response for a request issued before a reset SHALL be discarded.
REQ-028 First imem_req SHALL assert in the first clock edge cycle after async_reset rises, at reset_pc.

Structure
REQ-029 bits default, instruction width 32, PC increment 4, and NOP encoding 32'h00000013 SHALL live in the shared core package.
REQ-030 The 2-entry FIFO SHALL be a sub-module fetch_buffer (push, pop, flush, count, head), parameterised by entry width.
REQ-031 PC and counters SHALL use the codebase's enable-register style; no latches; all outputs glitch-free registered except imem_req/imem_addr.

Verification
REQ-032 Reset release, out_ready=1, IMEM returns word=addr -> out_pc 0,4,8,... one per cycle from cycle 2; out_instr matches.
REQ-033 out_ready=0 for 5 cycles after first valid -> at most 2 requests outstanding+buffered, out_pc held at 0, no lost/duplicated PC on resume.
REQ-034 Redirect to 0x100 while FIFO full and request in flight -> no pre-redirect instruction delivered; next out_pc=0x100 two cycles after redirect+1.
REQ-035 Redirect to 0x103 -> fetch resumes at 0x100.
REQ-036 PC at 2**bits-4 -> next out_pc 0 (wrap).
REQ-037 async_reset pulsed low mid-stream between edges -> outputs cleared immediately; restart at reset_pc; stale response ignored.
